// File: rtl/sum_uart_tx.sv
// Buffered 8N1 UART transmitter: bytes from the upstream adder are queued in a
// small FIFO and shifted out LSB first with no idle gap between queued frames.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            ready_en;
  logic            push, pop;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            tx_next;
  logic            baud_done;

  // ready_en keeps data_ready low until the first edge after reset release
  assign data_ready = ready_en && (fifo_count < 4'(FIFO_DEPTH));
  assign push       = data_valid && data_ready;
  assign baud_done  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy       = (state != IDLE) || (fifo_count != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 4'd0;
      overflow   <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + 4'(push) - 4'(pop);
      if (data_valid && !data_ready)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= data_in;
  end

  // Pops happen only from IDLE or on the last STOP cycle, so STOP->START chains frames
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (fifo_count != 4'd0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done)
          state_next = DATA;
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (baud_done && (bit_cnt == 3'd7))
          state_next = STOP;
      end
      STOP: begin
        if (baud_done) begin
          if (fifo_count != 4'd0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      if ((state_next != state) || (state == IDLE) || baud_done)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + CW'(1);
      if (pop) begin
        shift_reg <= fifo_mem[rd_ptr];
        bit_cnt   <= 3'd0;
      end else if ((state == DATA) && baud_done) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a line
// monitor decodes tx at bit centres into a queue of {stop, data} words.
module tb_sum_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [8:0] rx_q[$];
  int start_q[$];
  logic [7:0] exp_q[$];

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Sampling at falling edges: a start bit is first seen at offset 0, centres sit at 4b+2
  initial begin
    logic [7:0] b;
    b = 8'd0;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        start_q.push_back(cyc);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back({tx, b});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic v);
    data_in    = d;
    data_valid = v;
  endtask

  task automatic waitFrames(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      step(1);
      t++;
    end
    checkOutput("frame_count", rx_q.size(), n);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] exp);
    logic [8:0] got;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    else got = 9'h000;
    checkOutput(tag, got, {1'b1, exp});
  endtask

  task automatic flushMonitor();
    rx_q.delete();
    start_q.delete();
  endtask

  initial begin
    logic [9:0] fr;
    logic [7:0] d;
    logic       v;
    int         guard;

    // Reset values while rst_n is held low
    step(3);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_ready", data_ready, 0);
    rst_n = 1'b1;
    step(1);
    checkOutput("ready_after_rst", data_ready, 1);
    step(2);

    // Single 0xA5 frame with exact edge timing
    fr = {1'b1, 8'hA5, 1'b0};
    applyStimulus(8'hA5, 1'b1);
    step(1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("a5_count_k", fifo_count, 1);
    checkOutput("a5_busy_k", busy, 1);
    checkOutput("a5_tx_k", tx, 1);
    step(1);
    checkOutput("a5_tx_k1", tx, 1);
    checkOutput("a5_count_k1", fifo_count, 0);
    step(1);
    checkOutput("a5_tx_k2", tx, 0);
    step(2);
    for (int b = 0; b < 10; b++) begin
      checkOutput($sformatf("a5_bit%0d", b), tx, fr[b]);
      if (b < 9) step(CPB);
    end
    checkOutput("a5_busy_k40", busy, 1);
    step(1);
    checkOutput("a5_busy_k41", busy, 0);
    waitFrames(1, 20);
    checkFrame("a5_decoded", 8'hA5);
    step(5);

    // Three back-to-back frames
    flushMonitor();
    applyStimulus(8'h01, 1'b1); step(1);
    applyStimulus(8'h02, 1'b1); step(1);
    applyStimulus(8'h03, 1'b1); step(1);
    applyStimulus(8'h00, 1'b0);
    waitFrames(3, 200);
    checkFrame("b2b_0", 8'h01);
    checkFrame("b2b_1", 8'h02);
    checkFrame("b2b_2", 8'h03);
    checkOutput("b2b_starts", start_q.size(), 3);
    if (start_q.size() >= 3) begin
      checkOutput("b2b_gap01", start_q[1] - start_q[0], 10 * CPB);
      checkOutput("b2b_gap12", start_q[2] - start_q[1], 10 * CPB);
    end
    step(10);
    checkOutput("b2b_idle", busy, 0);

    // Fill while the first frame starts: fifth of six offered bytes is dropped
    flushMonitor();
    applyStimulus(8'h3C, 1'b1); step(1);
    applyStimulus(8'h00, 1'b0); step(1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h10 + 8'(i), 1'b1);
      step(1);
      checkOutput($sformatf("fill_count%0d", i), fifo_count, (i < 4) ? i + 1 : 4);
      checkOutput($sformatf("fill_ready%0d", i), data_ready, (i >= 3) ? 0 : 1);
      checkOutput($sformatf("fill_ovf%0d", i), overflow, (i >= 4) ? 1 : 0);
    end
    applyStimulus(8'h00, 1'b0);
    waitFrames(5, 300);
    checkFrame("fill_0", 8'h3C);
    checkFrame("fill_1", 8'h10);
    checkFrame("fill_2", 8'h11);
    checkFrame("fill_3", 8'h12);
    checkFrame("fill_4", 8'h13);
    step(20);
    checkOutput("fill_extra", rx_q.size(), 0);
    checkOutput("fill_ovf_sticky", overflow, 1);

    // Reset during data bit 3 of 0x00 with one byte still buffered
    flushMonitor();
    applyStimulus(8'h00, 1'b1); step(1);
    applyStimulus(8'h77, 1'b1); step(1);
    applyStimulus(8'h00, 1'b0);
    step(18);
    checkOutput("mid_tx_low", tx, 0);
    checkOutput("mid_count", fifo_count, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_tx", tx, 1);
    checkOutput("abort_count", fifo_count, 0);
    checkOutput("abort_ovf", overflow, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", data_ready, 0);
    step(2);
    rst_n = 1'b1;
    #1;
    checkOutput("release_ready0", data_ready, 0);
    step(1);
    checkOutput("release_ready1", data_ready, 1);
    step(50);
    flushMonitor();
    applyStimulus(8'hFF, 1'b1); step(1);
    applyStimulus(8'h00, 1'b0);
    waitFrames(1, 100);
    checkFrame("after_rst_ff", 8'hFF);
    step(20);
    checkOutput("after_rst_none", rx_q.size(), 0);

    // Offer a byte on the pop edge at the end of STOP with the FIFO full
    flushMonitor();
    applyStimulus(8'h55, 1'b1); step(1);
    applyStimulus(8'h00, 1'b0); step(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h20 + 8'(i), 1'b1);
      step(1);
    end
    applyStimulus(8'h00, 1'b0);
    step(35);
    checkOutput("pop_full_count", fifo_count, 4);
    checkOutput("pop_full_ready", data_ready, 0);
    checkOutput("pop_full_ovf", overflow, 0);
    applyStimulus(8'h99, 1'b1);
    step(1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("pop_count3", fifo_count, 3);
    checkOutput("pop_ovf", overflow, 1);
    waitFrames(5, 300);
    checkFrame("pop_0", 8'h55);
    checkFrame("pop_1", 8'h20);
    checkFrame("pop_2", 8'h21);
    checkFrame("pop_3", 8'h22);
    checkFrame("pop_4", 8'h23);
    step(20);

    // Random bytes with random valid gaps against the decoded stream
    flushMonitor();
    exp_q.delete();
    guard = 0;
    while (exp_q.size() < 20 && guard < 3000) begin
      v = ($urandom_range(0, 2) != 0);
      d = 8'($urandom);
      applyStimulus(d, v);
      if (v && data_ready) exp_q.push_back(d);
      step(1);
      guard++;
    end
    applyStimulus(8'h00, 1'b0);
    checkOutput("sb_accepted", exp_q.size(), 20);
    waitFrames(exp_q.size(), exp_q.size() * 10 * CPB + 200);
    while (exp_q.size() > 0) checkFrame("sb_byte", exp_q.pop_front());
    step(20);
    checkOutput("sb_extra", rx_q.size(), 0);
    checkOutput("sb_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
SUM_UART_TX -- requirements
Module: sum_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit; legal range 2..1023.
REQ-002 Parameter FIFO_DEPTH, default 4, input buffer entries; power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 data_in  input  8  byte to transmit, typically the adder sum from the upstream stage.
REQ-006 data_valid  input  1  data_in is offered this cycle.
REQ-007 data_ready  output  1  buffer can accept a byte this cycle.
REQ-008 tx  output  1  UART serial line, 8N1, idle high.
REQ-009 busy  output  1  frame in progress or buffer non-empty.
REQ-010 fifo_count  output  4  number of bytes currently buffered, 0..FIFO_DEPTH.
REQ-011 overflow  output  1  sticky flag: a byte was offered while the buffer was full.

Function
REQ-012 A byte is accepted on a rising edge when data_valid=1 and data_ready=1; it is written at the FIFO tail.
REQ-013 data_ready shall be 1 exactly when fifo_count < FIFO_DEPTH, using the registered count; it does not depend on a same-cycle pop.
REQ-014 data_valid=1 with data_ready=0 drops the byte, leaves FIFO contents unchanged, and sets overflow to 1 on that edge; overflow clears only on reset.
REQ-015 FIFO read/write pointers wrap modulo FIFO_DEPTH; a simultaneous push and pop leaves fifo_count unchanged and preserves order.
REQ-016 Transmit FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: tx=1; if fifo_count>0, pop head into shift register, clear bit counter, go to START on the same edge.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA: tx=shift register bit 0 for CLKS_PER_BIT cycles per bit, LSB first, shifting right after each bit; after bit 7 go to STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; on its last cycle, if fifo_count>0, pop and go directly to START, else go to IDLE.
REQ-021 Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have no idle gap.
REQ-022 tx shall be a register output, glitch-free; a byte accepted on edge k into an empty FIFO with FSM in IDLE drives tx low starting at edge k+2.
REQ-023 busy = (state != IDLE) OR (fifo_count != 0).
REQ-024 Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state transition.

Reset
REQ-025 While rst_n=0: state=IDLE, tx=1, fifo_count=0, pointers=0, overflow=0, busy=0, data_ready=0 during reset, 1 from the first edge after release.
REQ-026 Reset asserted mid-frame aborts the frame immediately; tx returns high asynchronously and buffered bytes are discarded.
REQ-027 No byte is accepted on the edge where rst_n is low.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Push 0xA5 once into idle block -> tx low from edge k+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; busy falls after 40 cycles.
REQ-029 Push 0x01,0x02,0x03 on consecutive cycles -> three frames in order, 120 cycles of tx activity, no high gap between stop and next start.
REQ-030 Push 6 bytes on consecutive cycles while first frame starts -> fifo_count peaks at 4, data_ready=0 at full, fifth offered byte dropped, overflow=1 and stays 1.
REQ-031 Assert rst_n=0 during DATA bit 3 of 0x00 -> tx=1 immediately, fifo_count=0, overflow=0; next pushed 0xFF transmits a complete frame.
REQ-032 With FIFO full and STOP ending, offer a byte on the pop edge -> byte rejected (data_ready was 0), overflow=1, fifo_count goes 4->3.
REQ-033 Scoreboard: random bytes with random valid gaps, sampled tx decoded at bit centres -> decoded stream equals accepted stream, none lost or reordered.
